// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port Data_Memory between the pipeline MEM
// stage (port A, priority) and the loader/debug DMA port (port B).
//
// Handshake: a requester raises req with its command fields stable and holds
// them until it sees a one-cycle ack. The request is latched in IDLE, the
// memory strobe is driven for exactly one cycle (ACCESS), and the winner gets
// its ack plus read data in the following cycle (DONE). Requests are not
// sampled in DONE, so a requester that keeps req high after its ack is seen
// as a fresh request in the next IDLE cycle. A request dropped after it has
// been latched still completes and is still acknowledged.
//
// Fairness: port A wins ties, but every A grant made while B is waiting bumps
// a saturating wait counter. Once it reaches B_MAX_WAIT, B wins the next tie.
module dmem_arbiter #(
  parameter int ADDR_W     = 16,
  parameter int DATA_W     = 16,
  parameter int B_MAX_WAIT = 4
) (
  input  logic              clk,
  input  logic              reset,
  // port A: pipeline MEM stage
  input  logic              a_req,
  input  logic              a_write,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic [DATA_W-1:0] a_wdata,
  output logic [DATA_W-1:0] a_rdata,
  output logic              a_ack,
  output logic              a_stall,
  // port B: loader / debug DMA
  input  logic              b_req,
  input  logic              b_write,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic [DATA_W-1:0] b_wdata,
  output logic [DATA_W-1:0] b_rdata,
  output logic              b_ack,
  // Data_Memory side
  output logic [ADDR_W-1:0] address,
  output logic [DATA_W-1:0] write_data,
  output logic              memWrite,
  output logic              memRead,
  input  logic [DATA_W-1:0] read_data,
  // debug: current FSM state (0 = IDLE, 1 = ACCESS, 2 = DONE)
  output logic [1:0]        dbg_state
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Saturation limit for the wait counter, sized to the 4-bit counter.
  localparam logic [3:0] WAIT_MAX = 4'(B_MAX_WAIT);

  // Word alignment mask: bit0 of every latched address is forced low.
  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~ADDR_W'(1);

  state_t            state_q,   state_d;
  logic              win_b_q,   win_b_d;    // 1 = current access belongs to B
  logic              wr_q,      wr_d;       // latched write flag
  logic [ADDR_W-1:0] addr_q,    addr_d;     // latched, word-aligned address
  logic [DATA_W-1:0] wdata_q,   wdata_d;    // latched write data
  logic [DATA_W-1:0] a_rdata_q, a_rdata_d;  // last read result for A
  logic [DATA_W-1:0] b_rdata_q, b_rdata_d;  // last read result for B
  logic [3:0]        wait_q,    wait_d;     // A grants while B was waiting

  logic b_wins;  // B takes this IDLE slot
  logic a_wins;  // A takes this IDLE slot

  // Arbitration decision for the current IDLE cycle.
  always_comb begin
    b_wins = b_req & (~a_req | (wait_q == WAIT_MAX));
    a_wins = a_req & ~b_wins;
  end

  // Next-state and datapath-register logic; everything holds by default.
  always_comb begin
    state_d   = state_q;
    win_b_d   = win_b_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wdata_d   = wdata_q;
    a_rdata_d = a_rdata_q;
    b_rdata_d = b_rdata_q;
    wait_d    = wait_q;

    case (state_q)
      IDLE: begin
        // B not waiting: nothing to be fair about, so forget the history.
        if (!b_req) begin
          wait_d = 4'd0;
        end
        if (b_wins) begin
          win_b_d = 1'b1;
          wr_d    = b_write;
          addr_d  = b_addr & ALIGN_MASK;
          wdata_d = b_wdata;
          wait_d  = 4'd0;
          state_d = ACCESS;
        end else if (a_wins) begin
          win_b_d = 1'b0;
          wr_d    = a_write;
          addr_d  = a_addr & ALIGN_MASK;
          wdata_d = a_wdata;
          // B was passed over once more; saturate rather than wrap.
          if (b_req && (wait_q != WAIT_MAX)) begin
            wait_d = wait_q + 4'd1;
          end
          state_d = ACCESS;
        end
      end

      ACCESS: begin
        // Memory read is combinational, so read_data is valid on this edge.
        if (!wr_q) begin
          if (win_b_q) begin
            b_rdata_d = read_data;
          end else begin
            a_rdata_d = read_data;
          end
        end
        state_d = DONE;
      end

      DONE: begin
        state_d = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      win_b_q   <= 1'b0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wdata_q   <= '0;
      a_rdata_q <= '0;
      b_rdata_q <= '0;
      wait_q    <= 4'd0;
    end else begin
      state_q   <= state_d;
      win_b_q   <= win_b_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wdata_q   <= wdata_d;
      a_rdata_q <= a_rdata_d;
      b_rdata_q <= b_rdata_d;
      wait_q    <= wait_d;
    end
  end

  // Output decode. Strobes and acks are gated by reset in the same cycle so
  // a reset during ACCESS never lets a write land and never produces an ack.
  always_comb begin
    address    = addr_q;
    write_data = wdata_q;
    memWrite   = (state_q == ACCESS) &  wr_q & ~reset;
    memRead    = (state_q == ACCESS) & ~wr_q & ~reset;
    a_ack      = (state_q == DONE) & ~win_b_q & ~reset;
    b_ack      = (state_q == DONE) &  win_b_q & ~reset;
    a_stall    = a_req & ~a_ack;
    a_rdata    = a_rdata_q;
    b_rdata    = b_rdata_q;
    dbg_state  = state_q;
  end

endmodule

// File: doc/dmem_arbiter.md
Name: dmem_arbiter

Overview:
- Shares the single-port 16-bit Data_Memory between two requesters:
  - Port A: pipeline MEM stage.
  - Port B: loader/debug DMA port.
- Latches one request at a time and drives the memory strobes for exactly one cycle.
- Returns read data and a one-cycle acknowledge to the winner.
- Port A has priority. A wait counter guarantees Port B a grant after a bounded number of A grants.

Parameters:
- ADDR_W, 16, address width presented to Data_Memory
- DATA_W, 16, data word width
- B_MAX_WAIT, 4, number of consecutive A grants while B is pending before B is forced to win (range 1..15)

Ports:
- clk  in  1  system clock; all state changes on rising edge
- reset  in  1  synchronous, active-high reset
- a_req  in  1  Port A request; held until a_ack
- a_write  in  1  Port A: 1 = write, 0 = read
- a_addr  in  ADDR_W  Port A byte address
- a_wdata  in  DATA_W  Port A write data
- a_rdata  out  DATA_W  Port A read data; valid while a_ack=1
- a_ack  out  1  Port A one-cycle completion pulse
- a_stall  out  1  pipeline stall = a_req & ~a_ack
- b_req  in  1  Port B request; held until b_ack
- b_write  in  1  Port B: 1 = write, 0 = read
- b_addr  in  ADDR_W  Port B byte address
- b_wdata  in  DATA_W  Port B write data
- b_rdata  out  DATA_W  Port B read data; valid while b_ack=1
- b_ack  out  1  Port B one-cycle completion pulse
- address  out  ADDR_W  to Data_Memory address
- write_data  out  DATA_W  to Data_Memory write_data
- memWrite  out  1  to Data_Memory memWrite
- memRead  out  1  to Data_Memory memRead
- read_data  in  DATA_W  from Data_Memory (combinational read)

Behaviour:
- Reset values: a_ack=b_ack=0, memWrite=memRead=0, address=0, write_data=0, a_rdata=b_rdata=0, wait count=0, state=IDLE.
- States: IDLE, ACCESS, DONE.
- IDLE:
  - Samples a_req/b_req on each edge. No request: stay in IDLE.
  - Winner selection: B wins if b_req & (~a_req | wait==B_MAX_WAIT); otherwise A wins if a_req.
  - On a grant: latch winner id, write flag, address (bit0 forced to 0, word-aligned) and wdata into registers; go to ACCESS.
- ACCESS (exactly 1 cycle):
  - address/write_data driven from the latched registers.
  - memWrite = latched write & ~reset; memRead = ~latched write & ~reset.
  - On the edge: capture read_data into the winner's rdata register (reads only; writes leave rdata unchanged); go to DONE.
- DONE (1 cycle):
  - Winner's ack=1. memRead=memWrite=0.
  - address/write_data hold their last values.
  - Next state is IDLE.
  - Requests are not sampled in DONE. A requester that keeps req high after its ack is treated as a new request in the following IDLE cycle.
- Latency and throughput:
  - Request first seen at edge N.
  - ACCESS during cycle N+1; ack during cycle N+2.
  - Throughput is one access per 3 cycles.
- Wait counter (4 bits, saturating at B_MAX_WAIT):
  - Increments on each A grant while b_req=1.
  - Clears on any B grant, and when b_req=0 in IDLE.
- Simultaneous a_req & b_req with wait < B_MAX_WAIT: A wins. With wait == B_MAX_WAIT: B wins.
- Request withdrawn after being latched: the access still completes and ack is still pulsed.
- Reset in any state:
  - Memory strobes are gated off in the same cycle, so no write lands.
  - No ack is issued.
  - Next state is IDLE and all registers return to their reset values.
- a_stall is combinational: high from a_req assertion through the cycle before a_ack.
- Odd address: bit0 is silently cleared. Address 0xFFFF maps to 0xFFFE with no wrap error.

Test Plan:
- A read alone: preload mem[0x0004]=0xBEEF; a_req=1, a_write=0, a_addr=0x0004 → memRead=1 exactly one cycle; a_ack pulses 2 cycles after request with a_rdata=0xBEEF; a_stall high for 2 cycles.
- B write then A read-back: b writes 0x1234 to 0x0010; then a reads 0x0011 → memWrite=1 one cycle with address=0x0010; a_rdata=0x1234 (odd address aligned).
- Contention/starvation: a_req and b_req held continuously, B_MAX_WAIT=4 → grant sequence A,A,A,A,B,A,A,A,A,B; b_ack every 15 cycles.
- Simultaneous first request with wait=0 → A granted first; B acked 3 cycles after a_ack.
- Reset during ACCESS of a B write to 0x0020 with data 0x5555 → memWrite=0 in that cycle; mem[0x0020] unchanged; no b_ack; state IDLE; all outputs at reset values next cycle.
- Withdrawn request: a_req drops in the ACCESS cycle → a_ack still pulses once; no second grant.
